// File: rtl/mp64_row_packer.sv
// Packs RATIO narrow beats into one wide row and issues one write per row on the SRAM wide port.
// Define MP64_ROWPACK_CSUM_EN to enable the running XOR row checksum on csum.
module mp64_row_packer #(
    parameter int unsigned ADDR_W_A = 14,
    parameter int unsigned DATA_W_A = 512,
    parameter int unsigned DATA_W_B = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W_A-1:0] cmd_row,
    input  logic [ADDR_W_A:0]   cmd_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W_B-1:0] in_data,
    input  logic                abort,
    output logic                a_ce,
    output logic                a_we,
    output logic [ADDR_W_A-1:0] a_addr,
    output logic [DATA_W_A-1:0] a_wdata,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [DATA_W_B-1:0] csum
);

    localparam int unsigned RATIO = DATA_W_A / DATA_W_B;
    localparam int unsigned CNT_W = $clog2(RATIO);

    typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

    state_e              state_q;
    logic [ADDR_W_A-1:0] cur_row_q;
    logic [ADDR_W_A:0]   rows_left_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic [DATA_W_A-1:0] row_buf_q;
    logic                done_q;
    logic                aborted_q;

    logic cmd_accept;
    logic beat_accept;
    logic last_beat;

    assign cmd_accept  = cmd_valid && (state_q == StIdle);
    assign beat_accept = in_valid && (state_q == StFill);
    assign last_beat   = (beat_cnt_q == CNT_W'(RATIO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_row_q   <= '0;
            rows_left_q <= '0;
            beat_cnt_q  <= '0;
            row_buf_q   <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // abort is ignored here; a concurrent command is still accepted
                    if (cmd_accept) begin
                        cur_row_q   <= cmd_row;
                        rows_left_q <= cmd_len;
                        beat_cnt_q  <= '0;
                        row_buf_q   <= '0;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StFill: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                    end else if (beat_accept) begin
                        for (int k = 0; k < RATIO; k++) begin
                            if (beat_cnt_q == CNT_W'(k)) begin
                                row_buf_q[k*DATA_W_B +: DATA_W_B] <= in_data;
                            end
                        end
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    rows_left_q <= rows_left_q - 1'b1;
                    cur_row_q   <= cur_row_q + 1'b1;
                    if (abort) begin
                        state_q   <= StIdle;
                        aborted_q <= 1'b1;
                    end else if (rows_left_q == (ADDR_W_A + 1)'(1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StFill;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign in_ready  = (state_q == StFill);
    assign busy      = (state_q != StIdle);
    assign a_ce      = (state_q == StWrite);
    assign a_we      = (state_q == StWrite);
    assign a_addr    = cur_row_q;
    assign a_wdata   = row_buf_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

`ifdef MP64_ROWPACK_CSUM_EN
    logic [DATA_W_B-1:0] csum_q;
    logic [DATA_W_B-1:0] lane_xor;

    always_comb begin
        lane_xor = '0;
        for (int k = 0; k < RATIO; k++) begin
            lane_xor = lane_xor ^ row_buf_q[k*DATA_W_B +: DATA_W_B];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (cmd_accept) begin
            csum_q <= '0;
        end else if (state_q == StWrite) begin
            csum_q <= csum_q ^ lane_xor;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_mp64_row_packer.sv
// Directed self-checking bench for mp64_row_packer: row packing, address wrap, stalls,
// abort, zero-length commands and asynchronous reset.
module tb_mp64_row_packer;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [13:0]  cmd_row;
    logic [14:0]  cmd_len;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         abort;
    logic         a_ce;
    logic         a_we;
    logic [13:0]  a_addr;
    logic [511:0] a_wdata;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [63:0]  csum;

    mp64_row_packer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_row   (cmd_row),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .a_ce      (a_ce),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .csum      (csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int           cyc = 0;
    logic [13:0]  wr_addr[$];
    logic [511:0] wr_data[$];
    int           wr_cyc[$];
    int           done_cnt;
    int           done_cyc;
    int           aborted_cnt;
    int           both_cnt;
    int           viol_cnt;
    int           busy_low;
    bit           mon_busy;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (a_ce) begin
            wr_addr.push_back(a_addr);
            wr_data.push_back(a_wdata);
            wr_cyc.push_back(cyc);
            if (in_ready || !a_we) viol_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            mon_busy = 1'b0;
        end
        if (aborted) aborted_cnt++;
        if (done && aborted) both_cnt++;
        if (mon_busy && !busy) busy_low++;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_row(input logic [63:0] base);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
        return r;
    endfunction

    function automatic logic [63:0] exp_csum(input logic [63:0] base, input int n);
        logic [63:0] x;
        x = '0;
`ifdef MP64_ROWPACK_CSUM_EN
        for (int i = 0; i < n; i++) x = x ^ (base + 64'(i));
`endif
        return x;
    endfunction

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        aborted_cnt = 0;
        both_cnt    = 0;
        viol_cnt    = 0;
        busy_low    = 0;
        mon_busy    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [13:0] row, input logic [14:0] len);
        cmd_valid = 1'b1;
        cmd_row   = row;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input logic [63:0] base, input int n, input bit gap);
        int t;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("beat_timeout", 512'd0, 512'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
            if (gap) @(negedge clk);
        end
    endtask

    // One single-row command with beats base..base+7, checked end to end
    task automatic one_row(input string tag, input logic [13:0] row, input logic [63:0] base);
        clear_mon();
        send_cmd(row, 15'd1);
        send_beats(base, 8, 1'b0);
        idle(3);
        check({tag, "_nwr"}, 512'(wr_addr.size()), 512'd1);
        if (wr_addr.size() == 1) begin
            check({tag, "_addr"}, 512'(wr_addr[0]), 512'(row));
            check({tag, "_data"}, wr_data[0], mk_row(base));
            check({tag, "_done_lat"}, 512'(done_cyc), 512'(wr_cyc[0] + 1));
        end
        check({tag, "_ndone"}, 512'(done_cnt), 512'd1);
        check({tag, "_csum"}, 512'(csum), 512'(exp_csum(base, 8)));
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_row   = '0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        clear_mon();
        #1;
        check("rst_cmd_ready", 512'(cmd_ready), 512'd1);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_in_ready", 512'(in_ready), 512'd0);
        check("rst_a_ce", 512'(a_ce), 512'd0);
        check("rst_done", 512'({done, aborted}), 512'd0);
        check("rst_addr", 512'(a_addr), 512'd0);
        check("rst_wdata", a_wdata, 512'd0);
        check("rst_csum", 512'(csum), 512'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // 1: single row, lane k = k+1
        one_row("s1", 14'h0010, 64'h1);

        // 2: address wrap across three rows
        clear_mon();
        send_cmd(14'h3FFF, 15'd3);
        send_beats(64'h100, 24, 1'b0);
        idle(3);
        check("s2_nwr", 512'(wr_addr.size()), 512'd3);
        if (wr_addr.size() == 3) begin
            check("s2_addr0", 512'(wr_addr[0]), 512'h3FFF);
            check("s2_addr1", 512'(wr_addr[1]), 512'h0000);
            check("s2_addr2", 512'(wr_addr[2]), 512'h0001);
            check("s2_data2", wr_data[2], mk_row(64'h110));
            check("s2_gap", 512'(wr_cyc[1] - wr_cyc[0]), 512'd9);
        end
        check("s2_ndone", 512'(done_cnt), 512'd1);
        check("s2_csum", 512'(csum), 512'(exp_csum(64'h100, 24)));

        // 3: stalled input produces the same rows
        clear_mon();
        send_cmd(14'h0200, 15'd2);
        mon_busy = 1'b1;
        send_beats(64'h1, 16, 1'b1);
        idle(3);
        check("s3_nwr", 512'(wr_addr.size()), 512'd2);
        if (wr_addr.size() == 2) begin
            check("s3_data0", wr_data[0], mk_row(64'h1));
            check("s3_data1", wr_data[1], mk_row(64'h9));
            check("s3_addr1", 512'(wr_addr[1]), 512'h0201);
        end
        check("s3_inready_in_write", 512'(viol_cnt), 512'd0);
        check("s3_busy_drop", 512'(busy_low), 512'd0);
        check("s3_ndone", 512'(done_cnt), 512'd1);

        // 4: abort mid-row, then a clean row
        clear_mon();
        send_cmd(14'h0020, 15'd2);
        send_beats(64'hA0, 5, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle(3);
        check("s4_nwr", 512'(wr_addr.size()), 512'd0);
        check("s4_naborted", 512'(aborted_cnt), 512'd1);
        check("s4_ndone", 512'(done_cnt), 512'd0);
        check("s4_idle", 512'({cmd_ready, busy}), 512'b10);
        check("s4_csum", 512'(csum), 512'd0);
        one_row("s4b", 14'h0030, 64'h11);

        // 5: zero-length command
        clear_mon();
        send_cmd(14'h0040, 15'd0);
        check("s5_done", 512'(done), 512'd1);
        check("s5_cmd_ready", 512'(cmd_ready), 512'd1);
        check("s5_a_ce", 512'(a_ce), 512'd0);
        @(negedge clk);
        check("s5_done_pulse", 512'(done), 512'd0);
        idle(2);
        check("s5_nwr", 512'(wr_addr.size()), 512'd0);

        // 6: asynchronous reset mid-row
        clear_mon();
        send_cmd(14'h0050, 15'd1);
        send_beats(64'hB0, 3, 1'b0);
        rst = 1'b1;
        #1;
        check("s6_busy", 512'(busy), 512'd0);
        check("s6_in_ready", 512'(in_ready), 512'd0);
        check("s6_a_ce", 512'(a_ce), 512'd0);
        check("s6_cmd_ready", 512'(cmd_ready), 512'd1);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check("s6_nwr", 512'(wr_addr.size()), 512'd0);
        one_row("s6b", 14'h0060, 64'h1);

        // 7: abort during the write cycle lets that write finish
        clear_mon();
        send_cmd(14'h0070, 15'd2);
        send_beats(64'h200, 8, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle(3);
        check("s7_nwr", 512'(wr_addr.size()), 512'd1);
        check("s7_naborted", 512'(aborted_cnt), 512'd1);
        check("s7_ndone", 512'(done_cnt), 512'd0);
        check("s7_csum", 512'(csum), 512'(exp_csum(64'h200, 8)));
        check("s7_done_and_aborted", 512'(both_cnt), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
